res_port_arb: RTL and testbench

RES_PORT_ARB -- requirements
Module: res_port_arb

---
 rtl/res_arb_pkg.sv | 26 ++
 rtl/rr_arb_pick.sv | 42 ++++
 rtl/res_port_arb.sv | 134 +++++++++++++
 tb/tb_res_port_arb.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/res_arb_pkg.sv
// ============================================================================
// Module  : res_arb_pkg
// Purpose : Shared sizing constants and requester IDs for the res port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package res_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 16;

  localparam int REQ_INIT = 0;
  localparam int REQ_FWD  = 1;
  localparam int REQ_BWD  = 2;

  // Width of a requester index; never below one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_pick.sv
// ============================================================================
// Module  : rr_arb_pick
// Purpose : Combinational round-robin pick; search starts at ptr and wraps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_pick
  import res_arb_pkg::*;
#(
  parameter int NUM_REQ = res_arb_pkg::NUM_REQ,
  parameter int ID_W    = res_arb_pkg::id_w(res_arb_pkg::NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    int              w_idx;
    logic            w_found;
    logic [ID_W-1:0] w_sel;
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(ptr) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      w_sel = ID_W'(w_idx);
      if (!w_found && req[w_sel]) begin
        gnt[w_sel] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/res_port_arb.sv
// ============================================================================
// Module  : res_port_arb
// Purpose : Round-robin arbiter sharing one res memory port among requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module res_port_arb
  import res_arb_pkg::*;
#(
  parameter int NUM_REQ = res_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = res_arb_pkg::ADDR_W,
  parameter int DATA_W  = res_arb_pkg::DATA_W,
  parameter int CNT_W   = res_arb_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      res_rd,
  output logic                      res_wr,
  output logic [ADDR_W-1:0]         res_addr,
  output logic [DATA_W-1:0]         res_do,
  input  logic [DATA_W-1:0]         res_di,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          grant_cnt,
  output logic                      busy
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_rd_id;
  logic               r_res_rd;
  logic               r_res_wr;
  logic [ADDR_W-1:0]  r_res_addr;
  logic [DATA_W-1:0]  r_res_do;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_acc;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic [NUM_REQ-1:0] w_rvalid_nxt;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_pick)
  );

  assign gnt   = reset ? '0 : w_pick;
  assign w_acc = |gnt;

  // gnt is one-hot, so OR-ing the selected fields yields the winner's command.
  always_comb begin
    w_gnt_id   = '0;
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        w_gnt_id   = w_gnt_id | ID_W'(k);
        w_sel_we   = w_sel_we | we[k];
        w_sel_addr = w_sel_addr | addr[k*ADDR_W +: ADDR_W];
        w_sel_data = w_sel_data | wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

  always_comb begin
    w_rvalid_nxt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_res_rd && (r_rd_id == ID_W'(k))) begin
        w_rvalid_nxt[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_rd_id    <= '0;
      r_res_rd   <= 1'b0;
      r_res_wr   <= 1'b0;
      r_res_addr <= '0;
      r_res_do   <= '0;
      r_rvalid   <= '0;
      r_cnt      <= '0;
    end else begin
      r_res_rd <= w_acc & ~w_sel_we;
      r_res_wr <= w_acc & w_sel_we;
      r_rvalid <= w_rvalid_nxt;
      if (w_acc) begin
        r_res_addr <= w_sel_addr;
        r_res_do   <= w_sel_data;
        r_ptr      <= w_ptr_nxt;
        r_rd_id    <= w_gnt_id;
      end
      // Clear wins over a same-cycle accept.
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_acc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign res_rd    = r_res_rd;
  assign res_wr    = r_res_wr;
  assign res_addr  = r_res_addr;
  assign res_do    = r_res_do;
  assign rvalid    = r_rvalid;
  assign rdata     = res_di;
  assign grant_cnt = r_cnt;
  assign busy      = r_res_rd | r_res_wr | (|r_rvalid);

endmodule

`default_nettype wire

// File: tb/tb_res_port_arb.sv
// ============================================================================
// Module  : tb_res_port_arb
// Purpose : Self-checking bench for res_port_arb with directed and random tests.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_res_port_arb;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int CW = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            res_rd;
  logic            res_wr;
  logic [AW-1:0]   res_addr;
  logic [DW-1:0]   res_do;
  logic [DW-1:0]   res_di;
  logic            cnt_clr;
  logic [CW-1:0]   grant_cnt;
  logic            busy;

  int n_tests;
  int n_fail;

  res_port_arb #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .res_rd    (res_rd),
    .res_wr    (res_wr),
    .res_addr  (res_addr),
    .res_do    (res_do),
    .res_di    (res_di),
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 4 units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req     = '0;
    we      = '0;
    addr    = '0;
    wdata   = '0;
    cnt_clr = 1'b0;
    res_di  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Round-robin reference: first requester at or after p (wrapping) wins.
  function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] g;
    g = '0;
    for (int o = 0; o < N; o++) begin
      int i;
      i = (p + o) % N;
      if (r[i] && g == '0) g[i] = 1'b1;
    end
    return g;
  endfunction

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    req = 3'b111;
    #3;
    n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rst_gnt got %b want 000", gnt); end
    n_tests++; if ({res_rd, res_wr} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b want 00", {res_rd, res_wr}); end
    n_tests++; if (res_addr !== '0 || res_do !== '0) begin n_fail++; $display("FAIL rst_cmd got addr=%0d do=%0d want 0", res_addr, res_do); end
    n_tests++; if (rvalid !== '0 || grant_cnt !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_misc got rvalid=%b cnt=%0d busy=%b want 0", rvalid, grant_cnt, busy); end
    req = '0;
    tick();
    reset = 1'b0;
    #3;
    n_tests++; if (gnt !== 3'b000 || grant_cnt !== '0) begin n_fail++; $display("FAIL rst_release got gnt=%b cnt=%0d want 000/0", gnt, grant_cnt); end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    req = 3'b010; we = 3'b000; addr[1*AW +: AW] = 14'd128;
    #3;
    n_tests++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rd_gnt got %b want 010", gnt); end
    tick();
    req = '0;
    #3;
    n_tests++; if (res_rd !== 1'b1 || res_wr !== 1'b0 || res_addr !== 14'd128) begin n_fail++; $display("FAIL rd_cmd got rd=%b wr=%b addr=%0d want 1/0/128", res_rd, res_wr, res_addr); end
    n_tests++; if (rvalid !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL rd_t1 got rvalid=%b busy=%b want 000/1", rvalid, busy); end
    tick();
    res_di = 8'h5A;
    #3;
    n_tests++; if (rvalid !== 3'b010 || rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_data got rvalid=%b rdata=%h want 010/5a", rvalid, rdata); end
    n_tests++; if (res_rd !== 1'b0) begin n_fail++; $display("FAIL rd_strobe_drop got %b want 0", res_rd); end
    tick();
    #3;
    n_tests++; if (rvalid !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_done got rvalid=%b busy=%b want 000/0", rvalid, busy); end
  endtask

  task automatic test_all_req();
    do_reset();
    req = 3'b111; we = 3'b111;
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] exp_g;
      exp_g = '0;
      exp_g[c % N] = 1'b1;
      #3;
      n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_seq[%0d] got %b want %b", c, gnt, exp_g); end
      tick();
    end
    #3;
    n_tests++; if (grant_cnt !== 4'd6) begin n_fail++; $display("FAIL rr_cnt got %0d want 6", grant_cnt); end
    req = '0;
    tick();
  endtask

  task automatic test_write();
    do_reset();
    req = 3'b001; we = 3'b001; addr[0 +: AW] = 14'd16383; wdata[0 +: DW] = 8'd1;
    #3;
    n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL wr_gnt got %b want 001", gnt); end
    tick();
    idle_inputs();
    #3;
    n_tests++; if (res_wr !== 1'b1 || res_rd !== 1'b0 || res_addr !== 14'd16383 || res_do !== 8'd1) begin n_fail++; $display("FAIL wr_cmd got wr=%b rd=%b addr=%0d do=%0d want 1/0/16383/1", res_wr, res_rd, res_addr, res_do); end
    tick();
    #3;
    n_tests++; if (rvalid !== 3'b000 || res_wr !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_after got rvalid=%b wr=%b busy=%b want 000/0/0", rvalid, res_wr, busy); end
    n_tests++; if (res_addr !== 14'd16383 || res_do !== 8'd1) begin n_fail++; $display("FAIL wr_hold got addr=%0d do=%0d want 16383/1", res_addr, res_do); end
    tick();
    #3;
    n_tests++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL wr_no_rvalid got %b want 000", rvalid); end
  endtask

  task automatic test_interleave();
    do_reset();
    req = 3'b010; we = 3'b000; addr[1*AW +: AW] = 14'd100;
    #3;
    n_tests++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL il_gnt1 got %b want 010", gnt); end
    tick();
    req = 3'b100; addr[2*AW +: AW] = 14'd200;
    #3;
    n_tests++; if (gnt !== 3'b100 || res_rd !== 1'b1 || res_addr !== 14'd100) begin n_fail++; $display("FAIL il_t1 got gnt=%b rd=%b addr=%0d want 100/1/100", gnt, res_rd, res_addr); end
    tick();
    req = '0; res_di = 8'h11;
    #3;
    n_tests++; if (rvalid !== 3'b010 || rdata !== 8'h11) begin n_fail++; $display("FAIL il_rv1 got rvalid=%b rdata=%h want 010/11", rvalid, rdata); end
    n_tests++; if (res_rd !== 1'b1 || res_addr !== 14'd200) begin n_fail++; $display("FAIL il_cmd2 got rd=%b addr=%0d want 1/200", res_rd, res_addr); end
    tick();
    res_di = 8'h22;
    #3;
    n_tests++; if (rvalid !== 3'b100 || rdata !== 8'h22) begin n_fail++; $display("FAIL il_rv2 got rvalid=%b rdata=%h want 100/22", rvalid, rdata); end
    tick();
    #3;
    n_tests++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL il_end got %b want 000", rvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b010; we = 3'b000; addr[1*AW +: AW] = 14'd77;
    tick();
    req = '0;
    #1;
    n_tests++; if (res_rd !== 1'b1) begin n_fail++; $display("FAIL rm_pre got rd=%b want 1", res_rd); end
    reset = 1'b1;
    req = 3'b111;
    #2;
    n_tests++; if (res_rd !== 1'b0 || res_addr !== '0 || rvalid !== '0 || grant_cnt !== '0 || busy !== 1'b0 || gnt !== '0) begin n_fail++; $display("FAIL rm_during got rd=%b addr=%0d rvalid=%b cnt=%0d busy=%b gnt=%b want all 0", res_rd, res_addr, rvalid, grant_cnt, busy, gnt); end
    tick();
    reset = 1'b0;
    #3;
    n_tests++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rm_no_rvalid got %b want 000", rvalid); end
    n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rm_first got %b want 001", gnt); end
    req = '0;
    tick();
    #3;
    n_tests++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL rm_no_rvalid2 got %b want 000", rvalid); end
  endtask

  task automatic test_saturate();
    do_reset();
    req = 3'b001; we = 3'b001;
    repeat (15) tick();
    #3;
    n_tests++; if (grant_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_15 got %0d want 15", grant_cnt); end
    tick();
    tick();
    #3;
    n_tests++; if (grant_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", grant_cnt); end
    cnt_clr = 1'b1;
    #1;
    n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL sat_clr_gnt got %b want 001", gnt); end
    tick();
    cnt_clr = 1'b0; req = '0;
    #3;
    n_tests++; if (grant_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr got %0d want 0", grant_cnt); end
    tick();
  endtask

  task automatic test_random();
    int           m_ptr;
    logic         m_rd, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_do;
    int           m_rd_id;
    logic [N-1:0] m_rv;
    int           m_cnt;
    logic [N-1:0] last_g;
    logic [N-1:0] exp_g;
    do_reset();
    m_ptr = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_do = '0; m_rd_id = 0; m_rv = '0; m_cnt = 0;
    last_g = '0;
    for (int c = 0; c < 400; c++) begin
      // A requester keeps its command until it has been granted.
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_g[i]) begin
          req[i]              = 1'($urandom % 2);
          we[i]               = 1'($urandom % 2);
          addr[i*AW +: AW]    = AW'($urandom);
          wdata[i*DW +: DW]   = DW'($urandom);
        end
      end
      cnt_clr = ($urandom % 16) == 0;
      res_di  = DW'($urandom);
      #3;
      exp_g = model_pick(req, m_ptr);
      n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, gnt, exp_g); end
      n_tests++; if (res_rd !== m_rd || res_wr !== m_wr) begin n_fail++; $display("FAIL rnd_strobe c=%0d got %b%b want %b%b", c, res_rd, res_wr, m_rd, m_wr); end
      n_tests++; if (res_addr !== m_addr || res_do !== m_do) begin n_fail++; $display("FAIL rnd_cmd c=%0d got %0d/%0d want %0d/%0d", c, res_addr, res_do, m_addr, m_do); end
      n_tests++; if (rvalid !== m_rv) begin n_fail++; $display("FAIL rnd_rvalid c=%0d got %b want %b", c, rvalid, m_rv); end
      if (m_rv != '0) begin
        n_tests++; if (rdata !== res_di) begin n_fail++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, rdata, res_di); end
      end
      n_tests++; if (int'(grant_cnt) !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, grant_cnt, m_cnt); end
      n_tests++; if (busy !== (m_rd || m_wr || m_rv != '0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, (m_rd || m_wr || m_rv != '0)); end
      // Advance the reference across the clock edge.
      m_rv = '0;
      if (m_rd) m_rv[m_rd_id] = 1'b1;
      m_rd = 1'b0; m_wr = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (exp_g[k]) begin
          m_rd    = !we[k];
          m_wr    = we[k];
          m_addr  = addr[k*AW +: AW];
          m_do    = wdata[k*DW +: DW];
          m_rd_id = k;
          m_ptr   = (k + 1) % N;
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if (exp_g != '0 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
      last_g = exp_g;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_all_req();
    test_write();
    test_interleave();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
